// File: rtl/rr_req_collect_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_req_collect_if
//  Brief    : Source / arbiter / grant bundle for rr_req_collect. Adds
//             drop_o / drop_clr_i when RR_REQ_DROP_FLAG_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface rr_req_collect_if #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT)
);
    logic [REQCNT-1:0]   src_req_i;
    logic [REQCNT-1:0]   src_full_o;
    logic [REQCNT-1:0]   arb_req_o;
    logic                arb_req_val_o;
    logic [REQWIDTH-1:0] arb_num_i;
    logic                gnt_valid_o;
    logic [REQWIDTH-1:0] gnt_num_o;
    logic                gnt_ready_i;
`ifdef RR_REQ_DROP_FLAG_EN
    logic [REQCNT-1:0]   drop_o;
    logic                drop_clr_i;
`endif

    modport master (
        input  src_req_i, arb_num_i, gnt_ready_i,
`ifdef RR_REQ_DROP_FLAG_EN
        input  drop_clr_i,
        output drop_o,
`endif
        output src_full_o, arb_req_o, arb_req_val_o, gnt_valid_o, gnt_num_o
    );

    modport slave (
        output src_req_i, arb_num_i, gnt_ready_i,
`ifdef RR_REQ_DROP_FLAG_EN
        output drop_clr_i,
        input  drop_o,
`endif
        input  src_full_o, arb_req_o, arb_req_val_o, gnt_valid_o, gnt_num_o
    );
endinterface
`default_nettype wire

// File: rtl/rr_req_collect.sv
`default_nettype none
// ============================================================================
//  Module   : rr_req_collect
//  Brief    : Per-source pending request counters feeding a round-robin
//             arbiter, with a valid/ready grant output. Optional sticky drop
//             flags under macro RR_REQ_DROP_FLAG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module rr_req_collect #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int CNTW     = 3
) (
    input  wire logic       clk_i,
    input  wire logic       rst_n_i,
    rr_req_collect_if.master bus
);

    localparam logic [CNTW-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_GNT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNTW-1:0]     r_cnt [REQCNT];
    logic                r_arb_req_val;
    logic                r_gnt_valid;
    logic [REQWIDTH-1:0] r_gnt_num;

    logic [REQCNT-1:0]   w_inc;
    logic [REQCNT-1:0]   w_dec;
    logic [REQCNT-1:0]   w_full;
    logic [REQCNT-1:0]   w_pending;
    logic                w_arb_hit;
    logic                w_accept;

    // Winner check is done by compare rather than indexing so an
    // out-of-range arbiter index simply fails the check.
    always_comb begin
        w_accept  = r_gnt_valid && bus.gnt_ready_i;
        w_arb_hit = 1'b0;
        w_inc     = '0;
        w_dec     = '0;
        w_full    = '0;
        w_pending = '0;
        for (int k = 0; k < REQCNT; k++) begin
            w_full[k]    = (r_cnt[k] == c_cnt_max);
            w_pending[k] = (r_cnt[k] != '0);
            w_inc[k]     = bus.src_req_i[k] && !w_full[k];
            w_dec[k]     = w_accept && (r_gnt_num == REQWIDTH'(k));
            if (bus.arb_num_i == REQWIDTH'(k) && w_pending[k])
                w_arb_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < REQCNT; k++)
                r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < REQCNT; k++) begin
                case ({w_inc[k], w_dec[k]})
                    2'b10:   r_cnt[k] <= r_cnt[k] + CNTW'(1);
                    2'b01:   r_cnt[k] <= r_cnt[k] - CNTW'(1);
                    default: r_cnt[k] <= r_cnt[k];
                endcase
            end
        end
    end

    // ARB lasts exactly one cycle so the arbiter advances once per grant.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state       <= ST_IDLE;
            r_arb_req_val <= 1'b0;
            r_gnt_valid   <= 1'b0;
            r_gnt_num     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        r_state       <= ST_ARB;
                        r_arb_req_val <= 1'b1;
                    end
                end
                ST_ARB: begin
                    r_arb_req_val <= 1'b0;
                    if (w_arb_hit) begin
                        r_gnt_num   <= bus.arb_num_i;
                        r_gnt_valid <= 1'b1;
                        r_state     <= ST_GNT;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_GNT: begin
                    if (bus.gnt_ready_i) begin
                        r_gnt_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_arb_req_val <= 1'b0;
                    r_gnt_valid   <= 1'b0;
                end
            endcase
        end
    end

`ifdef RR_REQ_DROP_FLAG_EN
    logic [REQCNT-1:0] r_drop;

    // A new drop in the same cycle as a clear keeps its flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            r_drop <= '0;
        else
            r_drop <= (r_drop & ~{REQCNT{bus.drop_clr_i}}) | (bus.src_req_i & w_full);
    end

    assign bus.drop_o = r_drop;
`endif

    assign bus.src_full_o    = w_full;
    assign bus.arb_req_o     = w_pending;
    assign bus.arb_req_val_o = r_arb_req_val;
    assign bus.gnt_valid_o   = r_gnt_valid;
    assign bus.gnt_num_o     = r_gnt_num;

endmodule
`default_nettype wire

// File: tb/tb_rr_req_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_req_collect
//  Brief    : Scoreboard bench for rr_req_collect with a round-robin arbiter
//             model. Drop-flag checks active when RR_REQ_DROP_FLAG_EN is set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_req_collect;
    localparam int REQCNT   = 5;
    localparam int REQWIDTH = $clog2(REQCNT);
    localparam int CNTW     = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_req_collect_if #(.REQCNT(REQCNT), .REQWIDTH(REQWIDTH)) bus();

    rr_req_collect #(.REQCNT(REQCNT), .REQWIDTH(REQWIDTH), .CNTW(CNTW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_chk   = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int strobes = 0;
    int q_exp[$];
    int acc_cyc[$];
    logic [REQWIDTH-1:0] r_ptr;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Round-robin arbiter: first requester at or after the priority pointer.
    always_comb begin
        bus.arb_num_i = '0;
        for (int j = REQCNT - 1; j >= 0; j--)
            if (bus.arb_req_o[(int'(r_ptr) + j) % REQCNT])
                bus.arb_num_i = REQWIDTH'((int'(r_ptr) + j) % REQCNT);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) r_ptr <= '0;
        else if (bus.arb_req_val_o) r_ptr <= REQWIDTH'((int'(bus.arb_num_i) + 1) % REQCNT);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.arb_req_val_o) strobes++;
            if (bus.gnt_valid_o && bus.gnt_ready_i) begin
                acc_cyc.push_back(cyc);
                if (q_exp.size() == 0) chk("sb_unexpected", int'(bus.gnt_num_o), -1);
                else                   chk("sb_gnt", int'(bus.gnt_num_o), q_exp.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.src_req_i   = '0;
        bus.gnt_ready_i = 1'b0;
`ifdef RR_REQ_DROP_FLAG_EN
        bus.drop_clr_i  = 1'b0;
`endif
        tick();
        tick();
        chk("rst_gnt_valid", int'(bus.gnt_valid_o), 0);
        chk("rst_gnt_num",   int'(bus.gnt_num_o), 0);
        chk("rst_arb_val",   int'(bus.arb_req_val_o), 0);
        chk("rst_arb_req",   int'(bus.arb_req_o), 0);
        chk("rst_src_full",  int'(bus.src_full_o), 0);
`ifdef RR_REQ_DROP_FLAG_EN
        chk("rst_drop",      int'(bus.drop_o), 0);
`endif
        q_exp.delete();
        acc_cyc.delete();
        strobes = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input int budget);
        int n;
        n = 0;
        while (!bus.gnt_valid_o && n < budget) begin
            tick();
            n++;
        end
        if (!bus.gnt_valid_o) chk("wait_gnt_timeout", 0, 1);
    endtask

    int s0;

    initial begin
        bus.src_req_i   = '0;
        bus.gnt_ready_i = 1'b0;
`ifdef RR_REQ_DROP_FLAG_EN
        bus.drop_clr_i  = 1'b0;
`endif

        // Single pulse latency
        do_reset();
        bus.src_req_i = 5'b00100; bus.gnt_ready_i = 1'b1; q_exp.push_back(2);
        chk("t1_c0_val", int'(bus.arb_req_val_o), 0);
        tick(); bus.src_req_i = '0;
        chk("t1_c1_req", int'(bus.arb_req_o), 4);
        chk("t1_c1_val", int'(bus.arb_req_val_o), 0);
        tick();
        chk("t1_c2_val", int'(bus.arb_req_val_o), 1);
        chk("t1_c2_gv",  int'(bus.gnt_valid_o), 0);
        tick();
        chk("t1_c3_gv",  int'(bus.gnt_valid_o), 1);
        chk("t1_c3_num", int'(bus.gnt_num_o), 2);
        chk("t1_c3_val", int'(bus.arb_req_val_o), 0);
        tick();
        chk("t1_c4_cnt", int'(dut.r_cnt[2]), 0);
        chk("t1_c4_req", int'(bus.arb_req_o), 0);
        chk("t1_c4_gv",  int'(bus.gnt_valid_o), 0);
        chk("t1_strobes", strobes, 1);
        chk("t1_sb_left", q_exp.size(), 0);

        // Rotation over sources 0,1,3
        do_reset();
        bus.gnt_ready_i = 1'b1; bus.src_req_i = 5'b01011;
        q_exp.push_back(0); q_exp.push_back(1); q_exp.push_back(3);
        tick(); bus.src_req_i = '0;
        repeat (12) tick();
        chk("t2_sb_left", q_exp.size(), 0);
        chk("t2_strobes", strobes, 3);
        chk("t2_n_acc", acc_cyc.size(), 3);
        if (acc_cyc.size() >= 3) begin
            chk("t2_gap01", acc_cyc[1] - acc_cyc[0], 3);
            chk("t2_gap12", acc_cyc[2] - acc_cyc[1], 3);
        end

        // Saturation
        do_reset();
        repeat (9) begin
            bus.src_req_i = 5'b10000;
            tick();
        end
        bus.src_req_i = '0;
        tick();
        chk("t3_cnt4", int'(dut.r_cnt[4]), 7);
        chk("t3_full", int'(bus.src_full_o), 16);
        chk("t3_gnum", int'(bus.gnt_num_o), 4);
`ifdef RR_REQ_DROP_FLAG_EN
        chk("t3_drop", int'(bus.drop_o), 16);
        bus.src_req_i = 5'b10000; bus.drop_clr_i = 1'b1;
        tick();
        chk("t3_drop_setwin", int'(bus.drop_o), 16);
        bus.src_req_i = '0;
        tick();
        bus.drop_clr_i = 1'b0;
        chk("t3_drop_clr", int'(bus.drop_o), 0);
`endif

        // Stalled grant
        do_reset();
        bus.src_req_i = 5'b00010;
        tick(); bus.src_req_i = '0;
        wait_gnt(10);
        s0 = strobes;
        for (int i = 0; i < 10; i++) begin
            bus.src_req_i = (i < 4) ? 5'b01001 : 5'b00000;
            tick();
            chk("t4_gv",  int'(bus.gnt_valid_o), 1);
            chk("t4_num", int'(bus.gnt_num_o), 1);
        end
        bus.src_req_i = '0;
        chk("t4_strobes", strobes, s0);
        chk("t4_cnt0", int'(dut.r_cnt[0]), 4);
        chk("t4_cnt3", int'(dut.r_cnt[3]), 4);
        bus.gnt_ready_i = 1'b1; q_exp.push_back(1);
        tick(); bus.gnt_ready_i = 1'b0;
        chk("t4_cnt1", int'(dut.r_cnt[1]), 0);
        chk("t4_sb_left", q_exp.size(), 0);

        // Increment and decrement in the same cycle
        do_reset();
        bus.src_req_i = 5'b00010;
        tick(); tick();
        bus.src_req_i = '0;
        wait_gnt(10);
        chk("t5_num", int'(bus.gnt_num_o), 1);
        chk("t5_cnt_pre", int'(dut.r_cnt[1]), 2);
        bus.gnt_ready_i = 1'b1; bus.src_req_i = 5'b00010; q_exp.push_back(1);
        tick();
        bus.gnt_ready_i = 1'b0; bus.src_req_i = '0;
        chk("t5_cnt_post", int'(dut.r_cnt[1]), 2);
        chk("t5_sb_left", q_exp.size(), 0);

        // Reset during GNT
        do_reset();
        bus.src_req_i = 5'b00100;
        tick(); bus.src_req_i = 5'b01001;
        tick(); bus.src_req_i = '0;
        wait_gnt(10);
        rst_n = 1'b0;
        tick();
        chk("t6_gv",    int'(bus.gnt_valid_o), 0);
        chk("t6_req",   int'(bus.arb_req_o), 0);
        chk("t6_val",   int'(bus.arb_req_val_o), 0);
        chk("t6_state", int'(dut.r_state), 0);
        for (int k = 0; k < REQCNT; k++)
            chk("t6_cnt", int'(dut.r_cnt[k]), 0);
        rst_n = 1'b1;
        s0 = strobes;
        repeat (4) tick();
        chk("t6_quiet_val", strobes, s0);
        chk("t6_quiet_gv",  int'(bus.gnt_valid_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
